// File: rtl/huff_pkg.sv
// rtl/huff_pkg.sv - shared defaults and state encoding for the Huffman bit store
package huff_pkg;

    localparam int BIT_WIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SERVE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/huff_bit_ram.sv
// rtl/huff_bit_ram.sv - DEPTH x BIT_WIDTH byte store, synchronous write, asynchronous read
module huff_bit_ram
    import huff_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [BIT_WIDTH-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [BIT_WIDTH-1:0] rdata
);

    logic [BIT_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/huff_bit_store.sv
// rtl/huff_bit_store.sv - buffers an encoded byte stream and serves it MSB-first one bit per request
module huff_bit_store
    import huff_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BIT_CNT_W = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [BIT_WIDTH-1:0] wr_byte_i,
    input  logic                 wr_last_i,
    input  logic [BIT_CNT_W-1:0] wr_nbits_i,
    input  logic                 rd_req_i,
    output logic                 st_bit_o,
    output logic                 bit_valid_o,
    output logic [BIT_CNT_W-1:0] total_bit_o,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int LO_W  = $clog2(BIT_WIDTH);

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [BIT_CNT_W-1:0]   bit_idx_q, bit_idx_d;
    logic [BIT_CNT_W-1:0]   total_q, total_d;
    logic [BIT_WIDTH-1:0]   shreg_q, shreg_d;
    logic                   ready_q, ready_d;

    logic                   ram_we;
    logic [AW-1:0]          ram_waddr;
    logic [AW-1:0]          ram_raddr;
    logic [BIT_WIDTH-1:0]   ram_rdata;

    logic [BIT_CNT_W:0]     idx_inc;
    logic [BIT_CNT_W-1:0]   next_word;
    logic [PTR_W:0]         nbytes;
    logic [31:0]            cap_bits;

    assign idx_inc   = {1'b0, bit_idx_q} + 1'b1;
    assign next_word = (bit_idx_q >> LO_W) + 1'b1;
    assign nbytes    = {1'b0, wr_ptr_q} + 1'b1;
    assign cap_bits  = 32'(BIT_WIDTH) * 32'(nbytes);
    assign ram_waddr = wr_ptr_q[AW-1:0];

    huff_bit_ram #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) u_ram (
        .clk_i (clk_i),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wr_byte_i),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            bit_idx_q <= '0;
            total_q   <= '0;
            shreg_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            bit_idx_q <= bit_idx_d;
            total_q   <= total_d;
            shreg_q   <= shreg_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        bit_idx_d = bit_idx_q;
        total_d   = total_q;
        shreg_d   = shreg_q;
        ready_d   = 1'b0;
        ram_we    = 1'b0;
        ram_raddr = (state_q == SERVE) ? next_word[AW-1:0] : '0;

        unique case (state_q)
            IDLE, FILL: begin
                if (wr_en_i) begin
                    if (wr_ptr_q == PTR_W'(DEPTH)) begin
                        state_d = ERROR;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        state_d  = FILL;
                        if (wr_last_i) begin
                            total_d = wr_nbits_i;
                            if (wr_nbits_i == '0) begin
                                state_d = DONE;
                            end else if (32'(wr_nbits_i) > cap_bits) begin
                                state_d = ERROR;
                            end else begin
                                state_d   = SERVE;
                                ready_d   = 1'b1;
                                bit_idx_d = '0;
                                // mem[0] is written on this same edge for a one-byte stream
                                shreg_d   = (wr_ptr_q == '0) ? wr_byte_i : ram_rdata;
                            end
                        end
                    end
                end
            end
            SERVE: begin
                if (rd_req_i) begin
                    bit_idx_d = idx_inc[BIT_CNT_W-1:0];
                    if (bit_idx_q[LO_W-1:0] == LO_W'(BIT_WIDTH - 1)) begin
                        shreg_d = ram_rdata;
                    end else begin
                        shreg_d = shreg_q << 1;
                    end
                    if (idx_inc == {1'b0, total_q}) begin
                        state_d = DONE;
                    end
                end
            end
            DONE, ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign st_bit_o    = (state_q == SERVE) & shreg_q[BIT_WIDTH-1];
    assign bit_valid_o = (state_q == SERVE);
    assign done_o      = (state_q == DONE);
    assign error_o     = (state_q == ERROR);
    assign ready_o     = ready_q;
    assign total_bit_o = total_q;

endmodule

// File: tb/tb_huff_bit_store.sv
// tb/tb_huff_bit_store.sv - scoreboard bench for huff_bit_store
module tb_huff_bit_store;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [7:0]  wr_byte_i;
    logic        wr_last_i;
    logic [10:0] wr_nbits_i;
    logic        rd_req_i;
    logic        st_bit_o;
    logic        bit_valid_o;
    logic [10:0] total_bit_o;
    logic        ready_o;
    logic        done_o;
    logic        error_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] byte_q [$];
    logic       exp_q  [$];

    always #5 clk_i = ~clk_i;

    huff_bit_store #(
        .BIT_WIDTH (8),
        .DEPTH     (256),
        .BIT_CNT_W (11)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_byte_i   (wr_byte_i),
        .wr_last_i   (wr_last_i),
        .wr_nbits_i  (wr_nbits_i),
        .rd_req_i    (rd_req_i),
        .st_bit_o    (st_bit_o),
        .bit_valid_o (bit_valid_o),
        .total_bit_o (total_bit_o),
        .ready_o     (ready_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        rst_i    = 1'b1;
        wr_en_i  = 1'b0;
        rd_req_i = 1'b0;
        tick;
        rst_i    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_st_bit"}, st_bit_o, 0);
        check({tag, "_valid"},  bit_valid_o, 0);
        check({tag, "_total"},  total_bit_o, 0);
        check({tag, "_ready"},  ready_o, 0);
        check({tag, "_done"},   done_o, 0);
        check({tag, "_error"},  error_o, 0);
    endtask

    // drive byte_q as one stream and push the MSB-first expected bits
    task automatic send_stream(input int nbits);
        for (int i = 0; i < byte_q.size(); i++) begin
            wr_en_i    = 1'b1;
            wr_byte_i  = byte_q[i];
            wr_last_i  = (i == byte_q.size() - 1);
            wr_nbits_i = nbits[10:0];
            tick;
        end
        wr_en_i   = 1'b0;
        wr_last_i = 1'b0;
        exp_q.delete();
        for (int i = 0; i < nbits; i++) begin
            logic [7:0] b;
            b = byte_q[i / 8];
            exp_q.push_back(b[7 - (i % 8)]);
        end
    endtask

    task automatic serve(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            check({tag, "_valid"}, bit_valid_o, 1);
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 1, 0);
            end else begin
                check({tag, "_bit"}, st_bit_o, exp_q.pop_front());
            end
            rd_req_i = 1'b1;
            tick;
            rd_req_i = 1'b0;
            if (k == 0) check({tag, "_ready_pulse"}, ready_o, 0);
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},   done_o, 1);
        check({tag, "_valid"},  bit_valid_o, 0);
        check({tag, "_st_bit"}, st_bit_o, 0);
        check({tag, "_error"},  error_o, 0);
    endtask

    initial begin
        rst_i      = 1'b1;
        wr_en_i    = 1'b0;
        wr_byte_i  = '0;
        wr_last_i  = 1'b0;
        wr_nbits_i = '0;
        rd_req_i   = 1'b0;

        do_reset;
        check_all_zero("rst");

        // single byte, 6 bits: 1,0,1,1,0,1
        byte_q = '{8'hB4};
        send_stream(6);
        check("b4_ready", ready_o, 1);
        check("b4_total", total_bit_o, 6);
        serve("b4", 6);
        check_done("b4");

        // byte-boundary reload, with an ignored write mid-serve
        do_reset;
        byte_q = '{8'hFF, 8'h00};
        send_stream(12);
        check("ff00_ready", ready_o, 1);
        serve("ff00a", 4);
        wr_en_i = 1'b1; wr_byte_i = 8'h55; wr_last_i = 1'b1; wr_nbits_i = 11'd1;
        tick;
        wr_en_i = 1'b0; wr_last_i = 1'b0;
        check("ff00_wr_ign_total", total_bit_o, 12);
        serve("ff00b", 8);
        check_done("ff00");

        // too many bits for one byte
        do_reset;
        byte_q = '{8'hA5};
        send_stream(9);
        check("a5_error", error_o, 1);
        check("a5_ready", ready_o, 0);
        check("a5_valid", bit_valid_o, 0);
        rd_req_i = 1'b1;
        tick; tick;
        rd_req_i = 1'b0;
        check("a5_sticky", error_o, 1);
        check("a5_st_bit", st_bit_o, 0);
        check("a5_done", done_o, 0);

        // exact fit: nbits == 8 * nbytes
        do_reset;
        byte_q = '{8'(($urandom_range(0, 255))), 8'(($urandom_range(0, 255))), 8'(($urandom_range(0, 255)))};
        send_stream(24);
        check("fit_ready", ready_o, 1);
        serve("fit", 24);
        check_done("fit");

        // full memory, largest representable stream
        do_reset;
        byte_q.delete();
        for (int i = 0; i < 256; i++) byte_q.push_back(8'($urandom_range(0, 255)));
        send_stream(2047);
        check("max_ready", ready_o, 1);
        check("max_total", total_bit_o, 2047);
        serve("max", 2047);
        check_done("max");

        // 257th write overflows
        do_reset;
        for (int i = 0; i < 256; i++) begin
            wr_en_i = 1'b1; wr_byte_i = 8'(i); wr_last_i = 1'b0;
            tick;
        end
        check("ovf_pre_error", error_o, 0);
        wr_byte_i = 8'hEE;
        tick;
        wr_en_i = 1'b0;
        check("ovf_error", error_o, 1);
        check("ovf_valid", bit_valid_o, 0);

        // zero-length stream
        do_reset;
        byte_q = '{8'h80};
        send_stream(0);
        check("zero_done", done_o, 1);
        check("zero_ready", ready_o, 0);
        check("zero_valid", bit_valid_o, 0);
        tick;
        check("zero_ready2", ready_o, 0);
        check("zero_done2", done_o, 1);

        // reset mid-serve wins over rd_req, then a fresh stream
        do_reset;
        byte_q = '{8'hC3, 8'h5A};
        send_stream(16);
        check("mid_ready", ready_o, 1);
        serve("mid", 3);
        rst_i = 1'b1; rd_req_i = 1'b1;
        tick;
        rst_i = 1'b0; rd_req_i = 1'b0;
        check_all_zero("midrst");
        byte_q = '{8'h40};
        send_stream(2);
        check("new_ready", ready_o, 1);
        check("new_total", total_bit_o, 2);
        serve("new", 2);
        check_done("new");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
